// File: rtl/grad_dir_pkg.sv
// rtl/grad_dir_pkg.sv - shared sizes, stage record and arctangent table for grad_dir_bin
//
// Holds the configuration the datapath is built around:
//   CFG_*   default widths and stage count of the quantiser
//   NBINS   number of orientation bins (2^BIN_W)
//   XW      integer width of the CORDIC x/y datapath (GW+2, room for -(-2^(GW-1)) and gain)
//   FW      fractional guard bits carried below the integer part of x/y
//   stage_t record passed from one pipeline stage to the next
//   atan_lut(ang_w, i) = round(atan(2^-i) * 2^ang_w / 2pi)
package grad_dir_pkg;

    localparam int CFG_GW    = 9;
    localparam int CFG_BIN_W = 5;
    localparam int CFG_ANG_W = 16;
    localparam int CFG_ITER  = 12;

    localparam int NBINS = 1 << CFG_BIN_W;
    localparam int XW    = CFG_GW + 2;
    // Guard bits keep the floor bias of y>>>i / x>>>i from piling up in the
    // magnitude and angle over the stages (a residual y of -1 would otherwise
    // add one LSB to x in every remaining stage).
    localparam int FW    = 5;
    localparam int DW    = XW + FW;

    typedef struct packed {
        logic                    valid;
        logic signed [DW-1:0]    x;
        logic signed [DW-1:0]    y;
        logic [CFG_ANG_W-1:0]    z;
        logic [CFG_BIN_W-1:0]    ref_bin;
        logic                    zero;
    } stage_t;

    // Elaboration-time only: arctangent by its Taylor series (t <= 1/2 for
    // i >= 1, so 16 terms are far below one angle LSB), pi/4 exactly for i = 0.
    function automatic longint unsigned atan_lut(input int ang_w, input int i);
        real pi;
        real t;
        real term;
        real acc;
        real turn;
        pi  = 3.14159265358979323846;
        acc = 0.0;
        if (i == 0) begin
            acc = pi / 4.0;
        end else begin
            t = 1.0;
            for (int k = 0; k < i; k++) begin
                t = t / 2.0;
            end
            term = t;
            for (int k = 0; k < 16; k++) begin
                acc  = acc + term / real'(2 * k + 1);
                term = -term * t * t;
            end
        end
        turn = 1.0;
        for (int k = 0; k < ang_w; k++) begin
            turn = turn * 2.0;
        end
        return longint'(acc * turn / (2.0 * pi));
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// rtl/cordic_vec_stage.sv - one CORDIC vectoring micro-rotation with its pipeline register
//
// Rotates (x, y) towards the +x axis by +-atan(2^-I) and accumulates the
// applied rotation in z (modulo one turn). The register loads only when en=1;
// its valid bit clears on rst, the data fields are not reset.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (valid only)
//   en       pipeline advance
//   stage_i  record from the previous stage
//   stage_o  registered record after this micro-rotation
module cordic_vec_stage
    import grad_dir_pkg::*;
#(
    parameter int I = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  stage_t stage_i,
    output stage_t stage_o
);

    localparam logic [CFG_ANG_W-1:0] ATAN_I = CFG_ANG_W'(atan_lut(CFG_ANG_W, I));

    stage_t               stage_d;
    stage_t               stage_q;
    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] y_sh;

    always_comb begin
        x_sh    = $signed(stage_i.x) >>> I;
        y_sh    = $signed(stage_i.y) >>> I;
        stage_d = stage_i;
        // Both updates use the pre-rotation x and y.
        if (!stage_i.y[DW-1]) begin
            stage_d.x = stage_i.x + y_sh;
            stage_d.y = stage_i.y - x_sh;
            stage_d.z = stage_i.z + ATAN_I;
        end else begin
            stage_d.x = stage_i.x - y_sh;
            stage_d.y = stage_i.y + x_sh;
            stage_d.z = stage_i.z - ATAN_I;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            stage_q <= stage_d;
        end
        if (rst) begin
            stage_q.valid <= 1'b0;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/grad_dir_bin.sv
// rtl/grad_dir_bin.sv - pipelined gradient-orientation quantiser relative to a reference bin
//
// Stage P folds the gradient into the right half-plane, ITER CORDIC stages
// measure its angle and magnitude, stage B rounds the angle to the nearest
// bin and subtracts ref_bin. The whole pipeline advances together whenever
// the output register is empty or being read (adv = ~out_valid | out_ready).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready = adv)
//   gx, gy               signed gradient components
//   ref_bin              dominant-orientation bin, travels with the sample
//   out_valid/out_ready  output handshake
//   out_bin              (round(theta) - ref_bin) mod NBINS
//   out_mag              |g| * CORDIC gain, integer part
//   out_zero             sample had gx = gy = 0
module grad_dir_bin
    import grad_dir_pkg::*;
#(
    parameter int GW    = CFG_GW,
    parameter int BIN_W = CFG_BIN_W,
    parameter int ANG_W = CFG_ANG_W,
    parameter int ITER  = CFG_ITER
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [GW-1:0]    gx,
    input  logic signed [GW-1:0]    gy,
    input  logic [BIN_W-1:0]        ref_bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        out_bin,
    output logic [GW:0]             out_mag,
    output logic                    out_zero
);

    localparam int               BIN_SH   = ANG_W - BIN_W;
    localparam logic [ANG_W-1:0] HALF_BIN = ANG_W'(1) << (BIN_SH - 1);

    logic adv;

    logic out_valid_q;
    logic [BIN_W-1:0] out_bin_q;
    logic [GW:0]      out_mag_q;
    logic             out_zero_q;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // Stage P: sign-extend, then rotate by 180 degrees when gx < 0 so the
    // CORDIC only ever sees x >= 0 (inside its +-99.9 degree range).
    logic signed [XW-1:0] gx_e;
    logic signed [XW-1:0] gy_e;
    stage_t               p_d;
    stage_t               p_q;

    assign gx_e = {{(XW - GW){gx[GW-1]}}, gx};
    assign gy_e = {{(XW - GW){gy[GW-1]}}, gy};

    always_comb begin
        p_d         = '0;
        p_d.valid   = in_valid;
        p_d.ref_bin = ref_bin;
        p_d.zero    = (gx == '0) && (gy == '0);
        if (gx[GW-1]) begin
            p_d.x = {-gx_e, {FW{1'b0}}};
            p_d.y = {-gy_e, {FW{1'b0}}};
            p_d.z = {1'b1, {(ANG_W - 1){1'b0}}};
        end else begin
            p_d.x = {gx_e, {FW{1'b0}}};
            p_d.y = {gy_e, {FW{1'b0}}};
            p_d.z = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            p_q <= p_d;
        end
        if (rst) begin
            p_q.valid <= 1'b0;
        end
    end

    // CORDIC vectoring chain
    stage_t chain [ITER+1];

    assign chain[0] = p_q;

    for (genvar s = 0; s < ITER; s++) begin : g_stage
        cordic_vec_stage #(
            .I (s)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (adv),
            .stage_i (chain[s]),
            .stage_o (chain[s+1])
        );
    end

    // Stage B: round to the nearest bin centre; the top BIN_W bits of the
    // wrapped sum give the bin, so angles just below a full turn land in bin 0.
    stage_t           last;
    logic [ANG_W-1:0] z_round;
    logic [BIN_W-1:0] abs_bin;
    logic [BIN_W-1:0] bin_d;
    logic [GW:0]      mag_d;

    assign last = chain[ITER];

    always_comb begin
        z_round = last.z + HALF_BIN;
        abs_bin = z_round[ANG_W-1 -: BIN_W];
        if (last.zero) begin
            bin_d = '0 - last.ref_bin;
            mag_d = '0;
        end else begin
            bin_d = abs_bin - last.ref_bin;
            mag_d = last.x[FW +: GW+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_mag_q   <= '0;
            out_zero_q  <= 1'b0;
        end else if (adv) begin
            out_valid_q <= last.valid;
            if (last.valid) begin
                out_bin_q  <= bin_d;
                out_mag_q  <= mag_d;
                out_zero_q <= last.zero;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_mag   = out_mag_q;
    assign out_zero  = out_zero_q;

    // Residual y, guard bits, the spare integer bit of x and the sub-bin
    // angle are intentionally dropped at the output.
    logic unused_bits;
    assign unused_bits = ^{last.y, last.x[FW-1:0], last.x[DW-1:FW+GW+1],
                           z_round[BIN_SH-1:0]};

endmodule

// File: tb/tb_grad_dir_bin.sv
// tb/tb_grad_dir_bin.sv - self-checking bench for grad_dir_bin
module tb_grad_dir_bin;

    localparam int  GW      = 9;
    localparam int  BIN_W   = 5;
    localparam int  ANG_W   = 16;
    localparam int  ITER    = 12;
    localparam int  NBINS   = 1 << BIN_W;
    localparam int  LAT     = ITER + 2;
    localparam int  NSTREAM = 40;
    localparam real BIN_DEG = 360.0 / NBINS;
    localparam real PI      = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [BIN_W-1:0]     ref_bin;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIN_W-1:0]     out_bin;
    logic [GW:0]          out_mag;
    logic                 out_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grad_dir_bin #(
        .GW    (GW),
        .BIN_W (BIN_W),
        .ANG_W (ANG_W),
        .ITER  (ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gx        (gx),
        .gy        (gy),
        .ref_bin   (ref_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_mag   (out_mag),
        .out_zero  (out_zero)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference model: real-valued geometry
    function automatic real angle_deg(input int x, input int y);
        real a;
        a = $atan2(real'(y), real'(x)) * 180.0 / PI;
        if (a < 0.0) a = a + 360.0;
        return a;
    endfunction

    function automatic int exp_bin(input int x, input int y, input int r);
        int b;
        if (x == 0 && y == 0) b = 0;
        else b = int'($floor(angle_deg(x, y) / BIN_DEG + 0.5)) % NBINS;
        return ((b - r) % NBINS + NBINS) % NBINS;
    endfunction

    function automatic real bin_margin(input int x, input int y);
        real f;
        real fr;
        f  = angle_deg(x, y) / BIN_DEG + 0.5;
        fr = f - $floor(f);
        return ((fr < 1.0 - fr) ? fr : 1.0 - fr) * BIN_DEG;
    endfunction

    function automatic real cordic_gain();
        real k;
        real p;
        k = 1.0;
        p = 1.0;
        for (int i = 0; i < ITER; i++) begin
            k = k * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        return k;
    endfunction

    function automatic int exp_mag(input int x, input int y);
        return int'($floor(cordic_gain() * $sqrt(real'(x * x + y * y))));
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_one(input string tag, input int x, input int y, input int r,
                           input int bin_e, input int mag_lo, input int mag_hi,
                           input int zero_e);
        int n;
        gx       = x[GW-1:0];
        gy       = y[GW-1:0];
        ref_bin  = r[BIN_W-1:0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk_eq({tag, ".in_ready"}, int'(in_ready), 1);
        cycle();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 4 * LAT) begin
            cycle();
            n++;
        end
        chk_eq({tag, ".latency"}, n, LAT);
        chk_eq({tag, ".bin"}, int'(out_bin), bin_e);
        chk_eq({tag, ".zero"}, int'(out_zero), zero_e);
        chk_rng({tag, ".mag"}, int'(out_mag), mag_lo, mag_hi);
        cycle();
        chk_eq({tag, ".drained"}, int'(out_valid), 0);
    endtask

    task automatic pick_sample(output int x, output int y, output int r);
        do begin
            x = int'($urandom_range(0, 511)) - 256;
            y = int'($urandom_range(0, 511)) - 256;
        end while ((x * x + y * y) < 64 * 64 || bin_margin(x, y) < 2.0);
        r = int'($urandom_range(0, NBINS - 1));
    endtask

    int d_gx [9] = '{100,   0, -100,    0, -256, 100,   0,  0, -256};
    int d_gy [9] = '{  0, 100,    0, -100, -256,  -5, -100, 0,    0};
    int d_ref[9] = '{  0,   0,    0,    0,    0,   0,  26,  3,    0};
    int d_bin[9] = '{  0,   8,   16,   24,   20,   0,  30, 29,   16};
    int d_mlo[9] = '{163, 163,  163,  163,  594, 163, 163,  0,  419};
    int d_mhi[9] = '{165, 165,  165,  165,  598, 165, 165,  0,  423};
    int d_zer[9] = '{  0,   0,    0,    0,    0,   0,   0,  1,    0};

    int sx [NSTREAM];
    int sy [NSTREAM];
    int sr [NSTREAM];
    int eb [NSTREAM];
    int em [NSTREAM];

    initial begin
        int sent;
        int rcv;
        int cyc;
        int tx;
        int ty;
        int tr;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        gx        = '0;
        gy        = '0;
        ref_bin   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst.out_valid", int'(out_valid), 0);
        chk_eq("rst.out_bin", int'(out_bin), 0);
        chk_eq("rst.out_mag", int'(out_mag), 0);
        chk_eq("rst.out_zero", int'(out_zero), 0);
        rst = 1'b0;
        cycle();
        chk_eq("rst.in_ready", int'(in_ready), 1);

        // Directed cases: axes, quadrants, wrap, zero, extreme input
        for (int i = 0; i < 9; i++) begin
            run_one($sformatf("dir%0d", i), d_gx[i], d_gy[i], d_ref[i],
                    d_bin[i], d_mlo[i], d_mhi[i], d_zer[i]);
        end

        // Random stream with backpressure (includes a 5-cycle stall)
        for (int i = 0; i < NSTREAM; i++) begin
            pick_sample(tx, ty, tr);
            sx[i] = tx;
            sy[i] = ty;
            sr[i] = tr;
            eb[i] = exp_bin(tx, ty, tr);
            em[i] = exp_mag(tx, ty);
        end
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        while (rcv < NSTREAM && cyc < 1000) begin
            in_valid = (sent < NSTREAM);
            if (sent < NSTREAM) begin
                gx      = sx[sent][GW-1:0];
                gy      = sy[sent][GW-1:0];
                ref_bin = sr[sent][BIN_W-1:0];
            end
            if (cyc >= 18 && cyc < 23) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk_eq("bp.in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid) begin
                chk_eq($sformatf("bp.bin[%0d]", rcv), int'(out_bin), eb[rcv]);
                chk_eq($sformatf("bp.zero[%0d]", rcv), int'(out_zero), 0);
                chk_rng($sformatf("bp.mag[%0d]", rcv), int'(out_mag), em[rcv] - 2, em[rcv] + 1);
                if (out_ready) rcv++;
            end
            if (in_valid && in_ready) sent++;
            cycle();
            cyc++;
        end
        chk_eq("bp.received", rcv, NSTREAM);
        chk_eq("bp.sent", sent, NSTREAM);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            chk_eq("bp.no_extra", int'(out_valid), 0);
            cycle();
        end

        // Reset with 6 samples in flight
        for (int i = 0; i < 6; i++) begin
            pick_sample(tx, ty, tr);
            gx       = tx[GW-1:0];
            gy       = ty[GW-1:0];
            ref_bin  = tr[BIN_W-1:0];
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        cycle();
        rst = 1'b0;
        chk_eq("mrst.in_ready", int'(in_ready), 1);
        for (int i = 0; i < LAT + 4; i++) begin
            chk_eq("mrst.flushed", int'(out_valid), 0);
            cycle();
        end
        run_one("post_rst", 0, 100, 0, 8, 163, 165, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grad_dir_bin.md
# grad_dir_bin

Parametrised, pipelined gradient-orientation quantiser for the SIFT descriptor path. It takes a signed pixel gradient (gx, gy) and the keypoint's dominant-orientation bin. It returns the orientation bin relative to that dominant orientation, modulo NBINS, plus an unscaled gradient magnitude. Arctangent and magnitude come from an ITER-stage CORDIC in vectoring mode, so the block supports any gradient width and any power-of-two bin count at one sample per cycle with valid/ready flow control.

## Interface
- GW, 9: gradient component width, signed two's complement.
- BIN_W, 5: bin index width. NBINS = 2^BIN_W.
- ANG_W, 16: internal angle width. One full turn = 2^ANG_W. Must be ≥ BIN_W+6.
- ITER, 12: CORDIC micro-rotation stages, 1..ANG_W-2.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- gx  in  GW  signed horizontal gradient.
- gy  in  GW  signed vertical gradient.
- ref_bin  in  BIN_W  dominant-orientation bin, sampled with gx/gy.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_bin  out  BIN_W  relative orientation bin.
- out_mag  out  GW+1  unsigned magnitude × CORDIC gain K≈1.6468.
- out_zero  out  1  input was gx=gy=0.

## Operation
- Angle convention: θ = atan2(gy, gx), counter-clockwise, 0 on +x axis, range [0, 2^ANG_W).
- Stage P (pre-rotation):
  - Sign-extend gx/gy to GW+2.
  - If gx<0: x=−gx, y=−gy, z=2^(ANG_W−1). Otherwise x=gx, y=gy, z=0.
  - gx = −2^(GW−1) must negate without overflow; the GW+2 width guarantees this.
- Stages 0..ITER−1 (vectoring): d = (y≥0).
  - x += d ? y>>>i : −(y>>>i)
  - y −= d ? x>>>i : −(x>>>i), using the pre-update x.
  - z += d ? ATAN[i] : −ATAN[i]
  - z arithmetic is modulo 2^ANG_W; wrap is intended.
- Stage B (bin):
  - abs_bin = (z + 2^(ANG_W−BIN_W−1)) >> (ANG_W−BIN_W), modulo NBINS. This rounds to the nearest bin, centred on k·2^ANG_W/NBINS; 2^ANG_W−ε wraps to bin 0.
  - out_bin = (abs_bin − ref_bin) mod NBINS.
  - out_mag = x truncated to GW+1 bits, never saturating, since max is 2^(GW−1)·√2·K < 2^(GW+1).
- Zero input: out_zero=1, out_mag=0, out_bin = (0 − ref_bin) mod NBINS. The z path is ignored.
- ref_bin and the zero flag travel down the pipeline alongside each sample.

## Timing
- Latency: ITER+2 cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no backpressure.
- Throughput: 1 sample/cycle.
- Flow control: global stall pipeline.
  - adv = ~out_valid | out_ready.
  - in_ready = adv, combinational from out_valid/out_ready only, never from in_valid.
  - Every stage register and valid bit updates only when adv=1.
- Simultaneous accept and emit in the same cycle is legal and loses nothing.
- While out_valid=1 and out_ready=0, out_bin/out_mag/out_zero hold stable.
- Reset:
  - All per-stage valid bits clear to 0.
  - out_valid=0, out_bin=0, out_mag=0, out_zero=0.
  - in_ready=1 in the cycle after rst deasserts.
  - Reset mid-stream drops all in-flight samples and produces no partial output.
- Data registers other than valid and the outputs need no reset.

## Structure
- Package grad_dir_pkg holds:
  - The ATAN constant function: round(atan(2^−i)·2^ANG_W/2π), ANG_W-generic, i=0..ANG_W−1.
  - The stage-record typedef {valid, x, y, z, ref_bin, zero}.
  - The localparams NBINS and XW=GW+2.
- Sub-module cordic_vec_stage (parameter I) holds one micro-rotation plus its register and enable. It is instantiated ITER times in a generate loop.
- The top level holds stage P, stage B and the handshake.

## Test plan
All cases use default parameters and out_ready=1 unless noted.
- gx=100, gy=0, ref_bin=0 → out_bin=0, out_mag=164±1, out_zero=0, ITER+2 cycles after accept.
- Quadrants with ref_bin=0:
  - (0,100) → 8
  - (−100,0) → 16
  - (0,−100) → 24
  - (−256,−256) → 20, out_mag=596±2
- Wrap cases:
  - (100,−5), ref_bin=0 → 0. This is −2.86°, which rounds up to bin 0.
  - (0,−100), ref_bin=26 → 30.
  - (0,0), ref_bin=3 → out_bin=29, out_zero=1, out_mag=0.
- Extreme input: (−256,0) → out_bin=16, out_mag=421±2, with no overflow.
- Backpressure: stream 40 random samples with in_valid=1 and out_ready toggled pseudo-randomly, including a 5-cycle low. Output must match the scoreboard in order, with no drops or duplicates, and outputs must hold stable while stalled.
- Reset: assert rst for 1 cycle with 6 samples in flight. No out_valid may follow from those samples. in_ready=1 next cycle, and the next sample's result appears ITER+2 cycles after its accept.
